instr_encoder: RTL and testbench

Inverse of the decode-side immediate generator. Accepts instruction fields (format, opcode, registers, funct, signed 32-bit immediate) and packs them into a 32-bit RV32I instruction word. The immediate is range- and alignment-checked against the format. Two-stage valid/ready pipeline sitting between the test/trace generator (or a self-modifying-code path) and instruction memory write port. Keeps encoded and error counters for debug.

---
 rtl/instr_encoder.sv | 154 +++++++++++++++
 tb/tb_instr_encoder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs instruction fields into a 32-bit RV32I instruction word. This is the
//   inverse of the decode-side immediate generator. The immediate is range- and
//   alignment-checked against the format. An illegal request produces NOP_WORD
//   with out_err set. Two register stages with a valid/ready handshake give
//   2-cycle latency and 1 word/cycle throughput.
//
// Ports
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready      request handshake (in_ready does not depend on in_valid)
//   in_fmt                   0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//                            instruction fields; in_imm is signed, byte offset for B/J
//   out_valid / out_ready    encoded-word handshake; output is held while stalled
//   out_instr, out_err       encoded word, illegal-request flag
//   enc_count                words handed off (wraps)
//   err_count                illegal words handed off (saturates)
module instr_encoder #(
    parameter int          CNT_W    = 16,
    parameter int          ERR_W    = 8,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Range/alignment check of the immediate for the given format.
    function automatic logic imm_legal(input logic [2:0] fmt, input logic signed [31:0] imm);
        logic ok;
        case (fmt)
            FMT_R:        ok = 1'b1;
            FMT_I, FMT_S: ok = (imm >= -32'sd2048) && (imm <= 32'sd2047);
            FMT_B:        ok = !imm[0] && (imm >= -32'sd4096) && (imm <= 32'sd4094);
            FMT_U:        ok = (imm[11:0] == 12'd0);
            FMT_J:        ok = !imm[0] && (imm >= -32'sd1048576) && (imm <= 32'sd1048574);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Field placement; fields that do not belong to a format stay zero.
    function automatic logic [31:0] encode(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = NOP_WORD;
        endcase
        return w;
    endfunction

    logic        vld_p1, vld_p2;
    logic        a_adv, b_adv;
    logic [2:0]  fmt_p1;
    logic [6:0]  op_p1;
    logic [4:0]  rd_p1, rs1_p1, rs2_p1;
    logic [2:0]  f3_p1;
    logic [6:0]  f7_p1;
    logic [31:0] imm_p1;
    logic        legal_p1;
    logic [31:0] instr_p2;
    logic        err_p2;

    assign b_adv     = !vld_p2 || out_ready;
    assign a_adv     = !vld_p1 || b_adv;
    assign in_ready  = a_adv;
    assign out_valid = vld_p2;
    assign out_instr = instr_p2;
    assign out_err   = err_p2;

    // ---- stage A: register request fields and the legality result ----
    always_ff @(posedge clk) begin
        if (a_adv && in_valid) begin
            fmt_p1   <= in_fmt;
            op_p1    <= in_opcode;
            rd_p1    <= in_rd;
            rs1_p1   <= in_rs1;
            rs2_p1   <= in_rs2;
            f3_p1    <= in_funct3;
            f7_p1    <= in_funct7;
            imm_p1   <= in_imm;
            legal_p1 <= imm_legal(in_fmt, in_imm);
        end
    end

    // ---- stage B: assemble the word; handshake and debug counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            instr_p2  <= 32'd0;
            err_p2    <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (a_adv) begin
                vld_p1 <= in_valid;
            end
            if (b_adv) begin
                vld_p2 <= vld_p1;
                // Only load on a real word so a drained stage keeps its last value.
                if (vld_p1) begin
                    instr_p2 <= legal_p1 ? encode(fmt_p1, op_p1, rd_p1, rs1_p1, rs2_p1,
                                                  f3_p1, f7_p1, imm_p1)
                                         : NOP_WORD;
                    err_p2   <= !legal_p1;
                end
            end
            if (vld_p2 && out_ready) begin
                enc_count <= enc_count + CNT_W'(1);
                if (err_p2 && (err_count != {ERR_W{1'b1}})) begin
                    err_count <= err_count + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Self-checking bench for instr_encoder. Requests are queued with their
//   expected {err, word}; a per-cycle driver presents them, and every handshake
//   on the output side is matched in order against the expected queue.
module tb_instr_encoder;

    localparam int CNT_W = 16;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_fmt = '0;
    logic [6:0]       in_opcode = '0;
    logic [4:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]       in_funct3 = '0;
    logic [6:0]       in_funct7 = '0;
    logic [31:0]      in_imm = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [ERR_W-1:0] err_count;

    instr_encoder #(.CNT_W(CNT_W), .ERR_W(ERR_W), .NOP_WORD(32'h0000_0013)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] fmt;
        logic [6:0] op;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        int         imm;
    } req_t;

    req_t        pend[$];
    logic [32:0] pexp[$];
    logic [32:0] exq[$];

    int  n_chk = 0;
    int  n_fail = 0;
    int  exp_enc = 0;
    int  exp_err = 0;
    bit  was_stall = 0;
    logic [31:0] held_instr;
    logic        held_err;

    int bnd[13] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4098,
                    1048574, 1048576, -1048576, -1048578, 4095};

    // Reference: shift-and-mask placement straight from the field tables.
    function automatic logic [32:0] model(req_t r);
        longint      im = r.imm;
        logic [31:0] u  = r.imm;
        logic [31:0] w;
        logic [31:0] base;
        bit          ok;
        base = 32'(r.op) | (32'(r.f3) << 12);
        case (r.fmt)
            3'd0: begin ok = 1; w = base | (32'(r.rd) << 7) | (32'(r.rs1) << 15)
                             | (32'(r.rs2) << 20) | (32'(r.f7) << 25); end
            3'd1: begin ok = (im >= -2048) && (im <= 2047);
                        w = base | (32'(r.rd) << 7) | (32'(r.rs1) << 15) | ((u & 32'hFFF) << 20); end
            3'd2: begin ok = (im >= -2048) && (im <= 2047);
                        w = base | ((u & 31) << 7) | (32'(r.rs1) << 15) | (32'(r.rs2) << 20)
                            | (((u >> 5) & 127) << 25); end
            3'd3: begin ok = (im % 2 == 0) && (im >= -4096) && (im <= 4094);
                        w = base | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8)
                            | (32'(r.rs1) << 15) | (32'(r.rs2) << 20)
                            | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31); end
            3'd4: begin ok = (im % 4096 == 0);
                        w = 32'(r.op) | (32'(r.rd) << 7) | (u & 32'hFFFF_F000); end
            3'd5: begin ok = (im % 2 == 0) && (im >= -1048576) && (im <= 1048574);
                        w = 32'(r.op) | (32'(r.rd) << 7) | (((u >> 12) & 255) << 12)
                            | (((u >> 11) & 1) << 20) | (((u >> 1) & 1023) << 21)
                            | (((u >> 20) & 1) << 31); end
            default: begin ok = 0; w = 0; end
        endcase
        if (!ok) return {1'b1, 32'h0000_0013};
        return {1'b0, w};
    endfunction

    function automatic req_t mk(logic [2:0] fmt, logic [6:0] op, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                                logic [6:0] f7, int imm);
        req_t r;
        r.fmt = fmt; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
        r.f3 = f3; r.f7 = f7; r.imm = imm;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   k;
        r = mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), 3'($urandom), 7'($urandom), 0);
        k = $urandom_range(0, 5);
        case (k)
            0: r.imm = int'($urandom_range(0, 32)) - 16;
            1: r.imm = bnd[$urandom_range(0, 12)];
            2: r.imm = int'($urandom);
            3: r.imm = (int'($urandom_range(0, 8000)) - 4000) & ~1;
            4: r.imm = int'($urandom) & 32'hFFFF_F000;
            default: r.imm = (int'($urandom_range(0, 2097152)) - 1048576) & ~1;
        endcase
        return r;
    endfunction

    // One clock: present head request, follow both handshakes, track stalls.
    task automatic cyc(input bit ordy, input bit ven);
        @(negedge clk);
        if (was_stall) begin
            n_chk++;
            if (out_valid !== 1'b1 || out_instr !== held_instr || out_err !== held_err) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b instr=%h err=%b, need v=1 instr=%h err=%b",
                         out_valid, out_instr, out_err, held_instr, held_err);
            end
        end
        if (ven && pend.size() > 0) begin
            in_valid  = 1'b1;
            in_fmt    = pend[0].fmt;  in_opcode = pend[0].op;
            in_rd     = pend[0].rd;   in_rs1    = pend[0].rs1;
            in_rs2    = pend[0].rs2;  in_funct3 = pend[0].f3;
            in_funct7 = pend[0].f7;   in_imm    = pend[0].imm;
        end else begin
            in_valid = 1'b0;
        end
        out_ready = ordy;
        #1;
        if (in_valid && in_ready) begin
            void'(pend.pop_front());
            exq.push_back(pexp.pop_front());
        end
        if (out_valid && out_ready) begin
            logic [32:0] e;
            n_chk++;
            if (exq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word: got instr=%h err=%b, need no word", out_instr, out_err);
            end else begin
                e = exq.pop_front();
                if ({out_err, out_instr} !== e) begin
                    n_fail++;
                    $display("FAIL word: got instr=%h err=%b, need instr=%h err=%b",
                             out_instr, out_err, e[31:0], e[32]);
                end
                exp_enc++;
                if (e[32] && exp_err < 255) exp_err++;
            end
        end
        was_stall  = out_valid && !out_ready;
        held_instr = out_instr;
        held_err   = out_err;
    endtask

    task automatic drain();
        int c = 0;
        while ((pend.size() > 0 || exq.size() > 0 || out_valid) && c < 2000) begin
            cyc(1'b1, 1'b1);
            c++;
        end
        @(negedge clk);
        n_chk++;
        if (pend.size() > 0 || exq.size() > 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending %0d outstanding, need 0 0",
                     pend.size(), exq.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        pend.delete(); pexp.delete(); exq.delete();
        exp_enc = 0; exp_err = 0; was_stall = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_err !== 1'b0 ||
            enc_count !== '0 || err_count !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b instr=%h err=%b enc=%0d errc=%0d, need all 0",
                     out_valid, out_instr, out_err, enc_count, err_count);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, need 1", in_ready);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        in_valid = 1'b1; in_fmt = 3'd1; in_opcode = 7'h13; in_rd = 5'd1; in_rs1 = 5'd2;
        in_rs2 = 5'd0; in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'hFFFF_FFFF;
        out_ready = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_accept: got in_ready=%b, need 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_early: got out_valid=%b one cycle after accept, need 0", out_valid);
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || out_instr !== 32'hFFF1_0093 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_word: got v=%b instr=%h err=%b, need v=1 instr=fff10093 err=0",
                     out_valid, out_instr, out_err);
        end
        exp_enc++;
        @(negedge clk);
        n_chk++;
        if (enc_count !== CNT_W'(exp_enc) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_count: got enc=%0d v=%b, need enc=%0d v=0", enc_count, out_valid, exp_enc);
        end
    endtask

    task automatic test_directed();
        pend.push_back(mk(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 8));
        pexp.push_back({1'b0, 32'h0051_2423});
        pend.push_back(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000));
        pexp.push_back({1'b0, 32'h1234_52B7});
        pend.push_back(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -4));
        pexp.push_back({1'b0, 32'hFE00_0EE3});
        pend.push_back(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 2048));
        pexp.push_back({1'b0, 32'h0010_00EF});
        pend.push_back(mk(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 12345));
        pexp.push_back({1'b0, 32'h4052_01B3});
        drain();
    endtask

    task automatic test_illegal();
        do_reset();
        pend.push_back(mk(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 3));
        pexp.push_back({1'b1, 32'h0000_0013});
        pend.push_back(mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 2048));
        pexp.push_back({1'b1, 32'h0000_0013});
        pend.push_back(mk(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 0));
        pexp.push_back({1'b1, 32'h0000_0013});
        drain();
        n_chk++;
        if (enc_count !== CNT_W'(3) || err_count !== ERR_W'(3)) begin
            n_fail++;
            $display("FAIL illegal_counts: got enc=%0d err=%0d, need 3 3", enc_count, err_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            req_t r = rand_req();
            pend.push_back(r);
            pexp.push_back(model(r));
        end
        for (int c = 0; c < 12; c++) begin
            cyc(!(c >= 3 && c <= 7), 1'b1);
            if (c == 7) begin
                n_chk++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_backpressure: got in_ready=%b with both stages full, need 0", in_ready);
                end
            end
        end
        drain();
        n_chk++;
        if (enc_count !== CNT_W'(exp_enc) || err_count !== ERR_W'(exp_err)) begin
            n_fail++;
            $display("FAIL b2b_counts: got enc=%0d err=%0d, need %0d %0d",
                     enc_count, err_count, exp_enc, exp_err);
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 260; i++) begin
            pend.push_back(mk(3'd6, 7'($urandom), 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 0));
            pexp.push_back({1'b1, 32'h0000_0013});
        end
        drain();
        n_chk++;
        if (err_count !== ERR_W'(exp_err) || exp_err != 255 || enc_count !== CNT_W'(exp_enc)) begin
            n_fail++;
            $display("FAIL err_saturate: got err=%0d enc=%0d, need err=%0d(255) enc=%0d",
                     err_count, enc_count, exp_err, exp_enc);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            req_t r = rand_req();
            pend.push_back(r);
            pexp.push_back(model(r));
        end
        for (int c = 0; c < 900 && pend.size() > 0; c++) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
        end
        drain();
        n_chk++;
        if (enc_count !== CNT_W'(exp_enc) || err_count !== ERR_W'(exp_err)) begin
            n_fail++;
            $display("FAIL random_counts: got enc=%0d err=%0d, need %0d %0d",
                     enc_count, err_count, exp_enc, exp_err);
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) begin
            req_t r = rand_req();
            pend.push_back(r);
            pexp.push_back(model(r));
        end
        for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || enc_count !== '0 || err_count !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_reset: got v=%b enc=%0d err=%0d in_ready=%b, need 0 0 0 1",
                     out_valid, enc_count, err_count, in_ready);
        end
        pend.delete(); pexp.delete(); exq.delete();
        exp_enc = 0; exp_err = 0; was_stall = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pend.push_back(mk(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, -1));
        pexp.push_back({1'b0, 32'hFFF1_0093});
        drain();
        n_chk++;
        if (enc_count !== CNT_W'(1) || err_count !== '0) begin
            n_fail++;
            $display("FAIL midop_after: got enc=%0d err=%0d, need 1 0", enc_count, err_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_illegal();
        test_back_to_back();
        test_err_saturate();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
